// File: rtl/mem_arbiter.sv
// Arbiter for the single RAM port shared by the instruction and data channels.
// Data normally wins. A streak counter lets a pending instruction fetch win after DSTREAK_MAX data completions in a row.
module mem_arbiter #(
  parameter int DSTREAK_MAX = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dwait,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DGNT = 2'd1,
    IGNT = 2'd2
  } state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;
  localparam logic [3:0] STREAK_MAX = 4'(DSTREAK_MAX);

  // Handshake: a requester holds its REN/WEN, address and data stable until its
  // wait is low for one cycle (completion). It may drop the request early to abort.
  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_dstreak;
  logic [3:0] w_next_dstreak;
  logic       w_d_req;
  logic       w_starve;

  assign w_d_req     = dREN | dWEN;
  assign w_starve    = iREN && (r_dstreak == STREAK_MAX);
  assign iload       = ramload;
  assign dload       = ramload;
  assign o_dbg_state = r_state;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= IDLE;
      r_dstreak <= 4'd0;
    end else begin
      r_state   <= w_next_state;
      r_dstreak <= w_next_dstreak;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_next_dstreak = r_dstreak;
    iwait          = 1'b1;
    dwait          = 1'b1;
    ramREN         = 1'b0;
    ramWEN         = 1'b0;
    ramaddr        = '0;
    ramstore       = '0;
    case (r_state)
      IDLE: begin
        if (w_d_req && !w_starve) w_next_state = DGNT;
        else if (iREN)            w_next_state = IGNT;
      end
      DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (!w_d_req) begin
          w_next_state = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          dwait        = 1'b0;
          w_next_state = IDLE;
          if (!iREN)                        w_next_dstreak = 4'd0;
          else if (r_dstreak != STREAK_MAX) w_next_dstreak = r_dstreak + 4'd1;
        end else if (ramstate == RAM_ERROR) begin
          w_next_state = IDLE;
        end
      end
      IGNT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        if (!iREN) begin
          w_next_state = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          iwait          = 1'b0;
          w_next_state   = IDLE;
          w_next_dstreak = 4'd0;
        end else if (ramstate == RAM_ERROR) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequential arbiter that shares the single RAM port between the instruction and data request channels issued by the caches block.
- Sits between the caches block's cache-control outputs and the RAM model.
- Registers a grant, drives the RAM with the owner's request, and releases the owner's wait on completion.
- Data has priority, bounded by a starvation limit so instruction fetches always progress.

Parameters:
- DSTREAK_MAX, 4: max consecutive data completions while iREN is pending before instruction is forced to win arbitration (range 1–15).
- ADDR_W, 32: address width.
- DATA_W, 32: data width.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  instruction read request.
- iaddr  in  ADDR_W  instruction address.
- iload  out  DATA_W  instruction read data.
- iwait  out  1  instruction wait; low for exactly the completion cycle.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  ADDR_W  data address.
- dstore  in  DATA_W  data write value.
- dload  out  DATA_W  data read data.
- dwait  out  1  data wait; low for exactly the completion cycle.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data.
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.

Behaviour:
- Reset (async, nRST low):
  - state=IDLE, dstreak=0.
  - iwait=1, dwait=1.
  - ramREN=ramWEN=0, ramaddr=0, ramstore=0.
  - Reset mid-transaction aborts immediately; the RAM sees enables drop in the same instant.
- iload and dload are combinational copies of ramload at all times. They are valid only when the respective wait is low.
- FSM states: IDLE, DGNT, IGNT. State and dstreak are registered; all outputs decode from state.
- IDLE:
  - ram enables 0; iwait=dwait=1.
  - Next state:
    - DGNT if (dREN|dWEN) and not (iREN and dstreak==DSTREAK_MAX).
    - else IGNT if iREN.
    - else IDLE.
  - Arbitration latency: 1 cycle from request to RAM enable.
- DGNT:
  - ramaddr=daddr, ramstore=dstore.
  - ramWEN=dWEN, ramREN=dREN&~dWEN (a write wins if both are asserted).
  - If ramstate==ACCESS: dwait=0 this cycle, next state IDLE.
  - dstreak update on completion: increment if iREN=1, saturating at DSTREAK_MAX; clear to 0 if iREN=0.
- IGNT:
  - ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
  - If ramstate==ACCESS: iwait=0, next state IDLE, dstreak=0.
- FREE/BUSY in a grant state: hold state, hold wait high.
- ERROR in a grant state: wait stays high, return to IDLE, re-arbitrate (retry). dstreak unchanged.
- Owner drops its request while granted (DGNT with dREN=dWEN=0, or IGNT with iREN=0):
  - Abort: RAM enables follow the request low combinationally, next state IDLE, no wait pulse.
- Completion forces one IDLE bubble cycle between any two transactions.
- Non-owner wait is always 1. Both waits are never low in the same cycle.
- Address/data changes while granted pass through combinationally; requesters must hold them stable per the caches contract.

Test Plan:
- Reset with iREN=1, ramstate=ACCESS held:
  - iwait=dwait=1 and ramREN=0 while nRST=0.
  - First ramREN=1 with ramaddr=iaddr one cycle after nRST rises.
- Lone instruction fetch iaddr=0x40, RAM BUSY 2 cycles then ACCESS with ramload=0xDEADBEEF:
  - iwait low exactly 1 cycle with iload=0xDEADBEEF.
  - Then IDLE for 1 cycle.
- Simultaneous iREN and dWEN (daddr=0x80, dstore=0x1234):
  - Data granted first: ramWEN=1, ramstore=0x1234.
  - Instruction served next.
- Continuous dREN and iREN with DSTREAK_MAX=4, single-cycle ACCESS:
  - Grant order D,D,D,D,I,D,D,D,D,I.
- dREN=dWEN=1:
  - ramWEN=1, ramREN=0.
- ERROR on first data access, ACCESS on retry:
  - dwait stays high through the ERROR.
  - Single dwait low pulse after the retry.
  - Exactly two RAM transactions observed.
